lc3_mem_responder: RTL and testbench
====================================

Name: lc3_mem_responder

Overview:
- Parametrised memory responder serving the LC3 instruction fetch port and data port, each with its own programmable wait-state latency.
- Successor to the fixed zero-latency memory hookup in the LC3 bench top; instantiated between the LC3 core and the bench interface.
- Generalises data width, address width, depth and per-port latency.
- Adds a completion handshake, a data-port write path and sticky protocol-error flags.

Parameters:
- DW, 16, data word width in bits.
- AW, 16, address width of pc and Data_addr.
- DEPTH, 256, memory words; power of two; index = address mod DEPTH.
- INSTR_LAT, 2, wait cycles on the instruction port; range 0..15.
- DATA_LAT, 3, wait cycles on the data port; range 0..15.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc  in  AW  instruction fetch address.
- instrmem_rd  in  1  fetch request strobe.
- Instr_dout  out  DW  fetched instruction word.
- complete_instr  out  1  one-cycle fetch completion pulse.
- Data_addr  in  AW  data access address.
- data_req  in  1  data access request strobe.
- Data_rd  in  1  access type: 1 = read, 0 = write; sampled with data_req.
- Data_dout  in  DW  write data from the core.
- Data_din  out  DW  read data to the core.
- complete_data  out  1  one-cycle data completion pulse.
- err_busy  out  1  sticky flag: request arrived while its port was busy.

Behaviour:
- Reset (async, active-high):
  - Instr_dout, Data_din, complete_instr, complete_data and err_busy clear to 0.
  - Both FSMs go to IDLE; both latency counters clear to 0.
  - Memory array contents are preserved.
- Each port runs an independent FSM with states IDLE, WAIT, DONE.
- IDLE:
  - Request strobe high at a rising edge: capture the address (plus Data_rd and Data_dout on the data port).
  - Load the counter with the port's LAT value, then go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - On a cycle where the counter is 0, go to DONE.
  - With LAT = 0, WAIT lasts exactly one cycle.
- DONE (one cycle):
  - Completion output high for exactly this cycle.
  - Read: the output data register loads mem[addr mod DEPTH] at the edge entering DONE, so the value is valid while complete is high.
  - Write: the memory is updated at the edge leaving DONE.
  - FSM returns to IDLE.
- Latency: request sampled at edge N gives complete high in the cycle after edge N+LAT+1. Total request-to-complete is LAT+2 edges.
- Output data holding:
  - Instr_dout holds its value until the next fetch completion.
  - Data_din holds until the next data read completion.
  - Writes leave Data_din unchanged.
- Busy requests: a strobe high while its FSM is in WAIT or DONE is ignored. err_busy sets and stays high until reset.
- Back-to-back: a strobe in the same cycle that DONE is high is treated as busy. A new request is accepted only in IDLE.
- Address wrap: only the low log2(DEPTH) bits are used; addresses above DEPTH-1 alias without error.
- Same-address collision: if an instruction read lands in the same edge as a data write commit, the read returns the old value. The write is visible to fetches completing at any later edge.
- Both ports may complete in the same cycle; the two ports never stall each other.
- Reset mid-transaction: the in-flight access is dropped and no completion is issued. A pending write is not committed.

Test Plan:
- Reset, then fetch: backdoor-load mem[0x10] = 16'h1234; pulse instrmem_rd with pc = 0x10 (INSTR_LAT = 2) -> complete_instr high exactly 4 edges after the request edge, Instr_dout = 16'h1234 and held afterwards.
- Write then read: data_req, Data_rd = 0, Data_addr = 0x20, Data_dout = 16'hBEEF -> complete_data after 5 edges. A following read of 0x20 -> Data_din = 16'hBEEF with complete_data. Data_din unchanged after the write.
- Collision: write 16'hAAAA to 0x30 (old value 16'h5555), timed so a fetch of 0x30 completes on the commit edge -> Instr_dout = 16'h5555; the next fetch of 0x30 returns 16'hAAAA.
- Busy and wrap: second instrmem_rd pulse during WAIT -> ignored, err_busy = 1 and sticky. Fetch of pc = 0x0110 with DEPTH = 256 -> returns mem[0x10].
- Reset mid-write: assert reset during WAIT of a write to 0x40 -> no complete_data, mem[0x40] unchanged, all outputs 0 immediately (asynchronous).
- Latency 0 and parallel ports: INSTR_LAT = DATA_LAT = 0 with both requests on the same edge -> both completions high together 2 edges later with correct data.

Source files
------------

// File: rtl/lc3_mem_responder.sv
// Dual-port LC3 memory responder: instruction fetch and data ports, each with its
// own wait-state latency, completion pulse and shared sticky busy-error flag.
//
// state  | meaning
// S_IDLE | waiting for a request strobe; request captured here only
// S_WAIT | latency counter running down; read data loaded when it hits 0
// S_DONE | completion pulse; a pending data write commits on the exit edge
module lc3_mem_responder #(
    parameter int DW        = 16,
    parameter int AW        = 16,
    parameter int DEPTH     = 256,
    parameter int INSTR_LAT = 2,
    parameter int DATA_LAT  = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] pc,
    input  logic          instrmem_rd,
    output logic [DW-1:0] Instr_dout,
    output logic          complete_instr,
    input  logic [AW-1:0] Data_addr,
    input  logic          data_req,
    input  logic          Data_rd,
    input  logic [DW-1:0] Data_dout,
    output logic [DW-1:0] Data_din,
    output logic          complete_data,
    output logic          err_busy
);
    localparam int         IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] ILAT = 4'(INSTR_LAT);
    localparam logic [3:0] DLAT = 4'(DATA_LAT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    logic [DW-1:0] mem_q [DEPTH];

    state_t        ip_st_q, ip_st_d;
    logic [3:0]    ip_cnt_q, ip_cnt_d;
    logic [IW-1:0] ip_addr_q, ip_addr_d;

    state_t        dp_st_q, dp_st_d;
    logic [3:0]    dp_cnt_q, dp_cnt_d;
    logic [IW-1:0] dp_addr_q, dp_addr_d;
    logic          dp_rd_q, dp_rd_d;
    logic [DW-1:0] dp_wdata_q, dp_wdata_d;

    logic [DW-1:0] instr_q, din_q;
    logic          err_q, err_d;
    logic          ip_load, dp_load, dp_commit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ip_st_q    <= S_IDLE;
            ip_cnt_q   <= '0;
            ip_addr_q  <= '0;
            dp_st_q    <= S_IDLE;
            dp_cnt_q   <= '0;
            dp_addr_q  <= '0;
            dp_rd_q    <= 1'b0;
            dp_wdata_q <= '0;
        end else begin
            ip_st_q    <= ip_st_d;
            ip_cnt_q   <= ip_cnt_d;
            ip_addr_q  <= ip_addr_d;
            dp_st_q    <= dp_st_d;
            dp_cnt_q   <= dp_cnt_d;
            dp_addr_q  <= dp_addr_d;
            dp_rd_q    <= dp_rd_d;
            dp_wdata_q <= dp_wdata_d;
        end
    end

    always_comb begin
        ip_st_d   = ip_st_q;
        ip_cnt_d  = ip_cnt_q;
        ip_addr_d = ip_addr_q;
        case (ip_st_q)
            S_IDLE: begin
                if (instrmem_rd) begin
                    ip_st_d   = S_WAIT;
                    ip_cnt_d  = ILAT;
                    ip_addr_d = IW'(pc);
                end
            end
            S_WAIT: begin
                if (ip_cnt_q == 4'd0) ip_st_d = S_DONE;
                else                  ip_cnt_d = ip_cnt_q - 4'd1;
            end
            S_DONE:  ip_st_d = S_IDLE;
            default: ip_st_d = S_IDLE;
        endcase
    end

    always_comb begin
        dp_st_d    = dp_st_q;
        dp_cnt_d   = dp_cnt_q;
        dp_addr_d  = dp_addr_q;
        dp_rd_d    = dp_rd_q;
        dp_wdata_d = dp_wdata_q;
        case (dp_st_q)
            S_IDLE: begin
                if (data_req) begin
                    dp_st_d    = S_WAIT;
                    dp_cnt_d   = DLAT;
                    dp_addr_d  = IW'(Data_addr);
                    dp_rd_d    = Data_rd;
                    dp_wdata_d = Data_dout;
                end
            end
            S_WAIT: begin
                if (dp_cnt_q == 4'd0) dp_st_d = S_DONE;
                else                  dp_cnt_d = dp_cnt_q - 4'd1;
            end
            S_DONE:  dp_st_d = S_IDLE;
            default: dp_st_d = S_IDLE;
        endcase
    end

    always_comb begin
        complete_instr = (ip_st_q == S_DONE);
        complete_data  = (dp_st_q == S_DONE);
        ip_load        = (ip_st_q == S_WAIT) && (ip_cnt_q == 4'd0);
        dp_load        = (dp_st_q == S_WAIT) && (dp_cnt_q == 4'd0) && dp_rd_q;
        dp_commit      = (dp_st_q == S_DONE) && !dp_rd_q;
        err_d          = err_q
                       | (instrmem_rd && (ip_st_q != S_IDLE))
                       | (data_req    && (dp_st_q != S_IDLE));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instr_q <= '0;
            din_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            if (ip_load) instr_q <= mem_q[ip_addr_q];
            if (dp_load) din_q   <= mem_q[dp_addr_q];
            err_q <= err_d;
        end
    end

    // Memory has no reset so its contents survive; reset forces S_IDLE, so no commit.
    always_ff @(posedge clock) begin
        if (dp_commit) mem_q[dp_addr_q] <= dp_wdata_q;
    end

    assign Instr_dout = instr_q;
    assign Data_din   = din_q;
    assign err_busy   = err_q;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Bench for lc3_mem_responder: vector table, hand-timed corner sequences and a
// randomized run against an event-schedule model of both ports.
module tb_lc3_mem_responder;
    localparam int DW = 16, AW = 16, DEPTH = 256, ILAT = 2, DLAT = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] pc, Data_addr;
    logic          instrmem_rd, data_req, Data_rd;
    logic [DW-1:0] Data_dout, Instr_dout, Data_din;
    logic          complete_instr, complete_data, err_busy;

    logic [AW-1:0] z_pc, z_Data_addr;
    logic          z_instrmem_rd, z_data_req, z_Data_rd;
    logic [DW-1:0] z_Data_dout, z_Instr_dout, z_Data_din;
    logic          z_complete_instr, z_complete_data, z_err_busy;

    int checks = 0, failures = 0;
    logic [DW-1:0] mm [DEPTH];

    typedef struct {
        bit            is_data;
        logic [AW-1:0] addr;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t tbl [8];

    lc3_mem_responder #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .INSTR_LAT(ILAT), .DATA_LAT(DLAT)) dut (
        .clock(clock), .reset(reset), .pc(pc), .instrmem_rd(instrmem_rd),
        .Instr_dout(Instr_dout), .complete_instr(complete_instr),
        .Data_addr(Data_addr), .data_req(data_req), .Data_rd(Data_rd),
        .Data_dout(Data_dout), .Data_din(Data_din), .complete_data(complete_data),
        .err_busy(err_busy)
    );

    lc3_mem_responder #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .INSTR_LAT(0), .DATA_LAT(0)) dut0 (
        .clock(clock), .reset(reset), .pc(z_pc), .instrmem_rd(z_instrmem_rd),
        .Instr_dout(z_Instr_dout), .complete_instr(z_complete_instr),
        .Data_addr(z_Data_addr), .data_req(z_data_req), .Data_rd(z_Data_rd),
        .Data_dout(z_Data_dout), .Data_din(z_Data_din), .complete_data(z_complete_data),
        .err_busy(z_err_busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [DW-1:0] pat(input int i);
        return DW'((i * 257) ^ 32'h3C5A);
    endfunction

    // edges = count of edges from the request edge to the edge at which the core sees complete
    task automatic fetch(input logic [AW-1:0] a, output logic [DW-1:0] d, output int edges);
        pc = a;
        instrmem_rd = 1'b1;
        tick();
        instrmem_rd = 1'b0;
        edges = -1;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (complete_instr) begin
                edges = t + 1;
                break;
            end
        end
        d = Instr_dout;
        tick();
    endtask

    task automatic dacc(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        output logic [DW-1:0] d, output int edges);
        Data_addr = a;
        Data_rd   = rd;
        Data_dout = wd;
        data_req  = 1'b1;
        tick();
        data_req = 1'b0;
        edges = -1;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (complete_data) begin
                edges = t + 1;
                break;
            end
        end
        d = Data_din;
        tick();
        if (!rd && edges > 0) mm[int'(a) % DEPTH] = wd;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] dv, old;
        int e, badlat, t, seen;
        int k, ip_cmp, ip_busy, ip_a, dp_cmp, dp_busy, dp_commit, dp_a;
        logic dp_rd;
        logic [DW-1:0] dp_wd, exp_instr, exp_din;
        logic exp_err;

        reset = 1'b1;
        pc = '0; instrmem_rd = 1'b0; Data_addr = '0; data_req = 1'b0; Data_rd = 1'b0; Data_dout = '0;
        z_pc = '0; z_instrmem_rd = 1'b0; z_Data_addr = '0; z_data_req = 1'b0; z_Data_rd = 1'b0; z_Data_dout = '0;
        tick();
        tick();
        chk("rst_instr_dout", Instr_dout, 0);
        chk("rst_data_din", Data_din, 0);
        chk("rst_complete_instr", complete_instr, 0);
        chk("rst_complete_data", complete_data, 0);
        chk("rst_err_busy", err_busy, 0);
        reset = 1'b0;
        tick();

        badlat = 0;
        for (int i = 0; i < DEPTH; i++) begin
            dacc(1'b0, AW'(i), pat(i), dv, e);
            if (e != DLAT + 2) badlat++;
        end
        chk("init_write_latency_errors", badlat, 0);

        dacc(1'b0, 16'h0010, 16'h1234, dv, e);
        fetch(16'h0010, dv, e);
        chk("fetch10_latency", e, ILAT + 2);
        chk("fetch10_data", dv, 16'h1234);
        tick(); tick(); tick();
        chk("fetch10_hold", Instr_dout, 16'h1234);

        tbl[0] = '{1'b0, 16'h0010, 16'h1234};
        tbl[1] = '{1'b0, 16'h0110, 16'h1234};
        tbl[2] = '{1'b1, 16'hFF10, 16'h1234};
        tbl[3] = '{1'b0, 16'h00FF, pat(255)};
        tbl[4] = '{1'b1, 16'h0000, pat(0)};
        tbl[5] = '{1'b0, 16'h8081, pat(8'h81)};
        tbl[6] = '{1'b1, 16'h0155, pat(8'h55)};
        tbl[7] = '{1'b0, 16'h0000, pat(0)};
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].is_data) begin
                dacc(1'b1, tbl[i].addr, '0, dv, e);
                chk($sformatf("tbl%0d_read_latency", i), e, DLAT + 2);
            end else begin
                fetch(tbl[i].addr, dv, e);
                chk($sformatf("tbl%0d_fetch_latency", i), e, ILAT + 2);
            end
            chk($sformatf("tbl%0d_data", i), dv, tbl[i].exp);
        end

        dacc(1'b0, 16'h0020, 16'hBEEF, dv, e);
        chk("write20_latency", e, DLAT + 2);
        chk("write20_din_unchanged", Data_din, pat(8'h55));
        dacc(1'b1, 16'h0020, '0, dv, e);
        chk("read20_data", dv, 16'hBEEF);

        // write to 0x30 commits on the same edge the fetch of 0x30 loads its data
        dacc(1'b0, 16'h0030, 16'h5555, dv, e);
        Data_addr = 16'h0030; Data_rd = 1'b0; Data_dout = 16'hAAAA; data_req = 1'b1;
        tick();
        data_req = 1'b0;
        tick();
        pc = 16'h0030; instrmem_rd = 1'b1;
        tick();
        instrmem_rd = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            tick();
            if (complete_instr) seen = 1;
        end
        chk("collision_complete_seen", seen, 1);
        chk("collision_old_value", Instr_dout, 16'h5555);
        tick(); tick(); tick();
        mm[8'h30] = 16'hAAAA;
        fetch(16'h0030, dv, e);
        chk("collision_new_value", dv, 16'hAAAA);

        chk("busy_err_before", err_busy, 0);
        pc = 16'h0010; instrmem_rd = 1'b1;
        tick();
        pc = 16'h0020;
        tick();
        instrmem_rd = 1'b0;
        chk("busy_err_set", err_busy, 1);
        t = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (complete_instr) begin
                t = i;
                break;
            end
        end
        chk("busy_orig_ticks", t, ILAT);
        chk("busy_orig_data", Instr_dout, 16'h1234);
        tick(); tick(); tick();
        chk("busy_err_sticky", err_busy, 1);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("err_cleared_by_reset", err_busy, 0);
        tick();

        k = 0;
        ip_cmp = -1; ip_busy = -1; ip_a = 0;
        dp_cmp = -1; dp_busy = -1; dp_commit = -1; dp_a = 0; dp_rd = 1'b1; dp_wd = '0;
        exp_instr = '0; exp_din = '0; exp_err = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (c < 1970) begin
                instrmem_rd = ($urandom_range(0, 3) == 0);
                data_req    = ($urandom_range(0, 3) == 0);
            end else begin
                instrmem_rd = 1'b0;
                data_req    = 1'b0;
            end
            pc        = AW'($urandom) & 16'hFF0F;
            Data_addr = AW'($urandom) & 16'hFF0F;
            Data_rd   = 1'($urandom);
            Data_dout = DW'($urandom);
            k++;
            if (k == ip_cmp) exp_instr = mm[ip_a];
            if (k == dp_cmp && dp_rd) exp_din = mm[dp_a];
            if (k == dp_commit) mm[dp_a] = dp_wd;
            if (instrmem_rd) begin
                if (k > ip_busy) begin
                    ip_a = int'(pc) % DEPTH;
                    ip_cmp = k + ILAT + 1;
                    ip_busy = k + ILAT + 2;
                end else exp_err = 1'b1;
            end
            if (data_req) begin
                if (k > dp_busy) begin
                    dp_a = int'(Data_addr) % DEPTH;
                    dp_rd = Data_rd;
                    dp_wd = Data_dout;
                    dp_cmp = k + DLAT + 1;
                    dp_busy = k + DLAT + 2;
                    dp_commit = Data_rd ? -1 : k + DLAT + 2;
                end else exp_err = 1'b1;
            end
            tick();
            chk("rand_complete_instr", complete_instr, (k == ip_cmp));
            chk("rand_complete_data", complete_data, (k == dp_cmp));
            chk("rand_instr_dout", Instr_dout, exp_instr);
            chk("rand_data_din", Data_din, exp_din);
            chk("rand_err_busy", err_busy, exp_err);
        end
        instrmem_rd = 1'b0;
        data_req = 1'b0;
        tick();

        // in-flight write dropped by an asynchronous reset during WAIT
        dacc(1'b0, 16'h0040, 16'h0F0F, dv, e);
        fetch(16'h0040, dv, e);
        dacc(1'b1, 16'h0040, '0, dv, e);
        old = mm[8'h40];
        Data_addr = 16'h0040; Data_rd = 1'b0; Data_dout = 16'hDEAD; data_req = 1'b1;
        tick();
        data_req = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1;
        chk("midrst_instr_dout", Instr_dout, 0);
        chk("midrst_data_din", Data_din, 0);
        chk("midrst_complete_data", complete_data, 0);
        chk("midrst_complete_instr", complete_instr, 0);
        chk("midrst_err_busy", err_busy, 0);
        tick();
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (complete_data) seen = 1;
        end
        chk("midrst_no_complete", seen, 0);
        dacc(1'b1, 16'h0040, '0, dv, e);
        chk("midrst_mem_unchanged", dv, old);

        z_Data_addr = 16'h0005; z_Data_rd = 1'b0; z_Data_dout = 16'hABCD; z_data_req = 1'b1;
        tick();
        z_data_req = 1'b0;
        chk("lat0_write_not_yet", z_complete_data, 0);
        tick();
        chk("lat0_write_complete", z_complete_data, 1);
        tick();
        z_pc = 16'h0105; z_instrmem_rd = 1'b1;
        z_Data_addr = 16'h0205; z_Data_rd = 1'b1; z_data_req = 1'b1;
        tick();
        z_instrmem_rd = 1'b0;
        z_data_req = 1'b0;
        chk("lat0_instr_wait", z_complete_instr, 0);
        chk("lat0_data_wait", z_complete_data, 0);
        tick();
        chk("lat0_instr_complete", z_complete_instr, 1);
        chk("lat0_data_complete", z_complete_data, 1);
        chk("lat0_instr_data", z_Instr_dout, 16'hABCD);
        chk("lat0_data_data", z_Data_din, 16'hABCD);
        tick();
        chk("lat0_instr_pulse_end", z_complete_instr, 0);
        chk("lat0_data_pulse_end", z_complete_data, 0);
        chk("lat0_err_busy", z_err_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
